request_arbiter: RTL and testbench
==================================

REQUEST_ARBITER -- requirements
Module: request_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 15, meaning the maximum number of cycles a grant is held while other requests are pending (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-004 The block SHALL have port req, input, 8, request lines; req[i]=1 means requester i wants or holds the resource.
REQ-005 The block SHALL have port rr_en, input, 1, arbitration mode; 1 = round-robin, 0 = fixed priority (index 7 highest).
REQ-006 The block SHALL have port gnt, output, 8, one-hot grant, registered.
REQ-007 The block SHALL have port gnt_id, output, 3, binary index of the granted requester, registered.
REQ-008 The block SHALL have port gnt_valid, output, 1, 1 when a grant is active, registered.
REQ-009 The block SHALL have port preempt, output, 1, one-cycle pulse on the cycle a grant changes because of HOLD_MAX timeout.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE (no grant) and BUSY (grant held).
REQ-011 In IDLE with req!=0, the winner SHALL be registered the next edge: gnt, gnt_id and gnt_valid change together, state goes to BUSY, and latency is 1 cycle.
REQ-012 In IDLE with req==0, all outputs SHALL stay 0.
REQ-013 Fixed mode (rr_en=0) SHALL select the highest set index of the candidate set.
REQ-014 Round-robin mode (rr_en=1) SHALL select the first set index searching downward from last_id-1 and wrapping 0->7, where last_id is the most recently granted index.
REQ-015 In BUSY, the grant SHALL be held unchanged while req[gnt_id]=1 and hold_cnt<HOLD_MAX.
REQ-016 Release: when req[gnt_id]=0 in BUSY, the block SHALL arbitrate among the remaining req bits that cycle; if any are set, the new grant is registered at the next edge with no idle gap; if none are set, it goes to IDLE and clears gnt, gnt_id and gnt_valid at the next edge.
REQ-017 hold_cnt SHALL clear on every new grant, increment each BUSY cycle in which other req bits are set, and saturate at HOLD_MAX.
REQ-018 Timeout: when hold_cnt==HOLD_MAX and other requests are pending, the grant SHALL move to the next winner (per mode, holder excluded) at the next edge, with preempt=1 for that cycle.
REQ-019 Timeout with no other pending request SHALL keep the holder granted, with no preempt pulse.
REQ-020 The holder SHALL be excluded from the candidate set on release and timeout; in all other cases the full req vector is the candidate set.
REQ-021 A change of rr_en SHALL affect only the next arbitration decision, never an active grant.
REQ-022 gnt SHALL always equal one-hot(gnt_id) when gnt_valid=1, and SHALL be 0 when gnt_valid=0.
REQ-023 Simultaneous holder release and timeout SHALL be treated as a release, with preempt=0.

Reset
REQ-024 On rst=1 at a clock edge, the block SHALL set state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, preempt=0, hold_cnt=0 and last_id=0, so the first round-robin search starts at index 7.
REQ-025 Reset asserted mid-grant SHALL drop the grant at that edge regardless of req.
REQ-026 The first arbitration SHALL happen on the first edge with rst=0.

Structure
REQ-027 Package arb_pkg SHALL hold N_REQ=8, ID_W=3 and the FSM state enum {IDLE, BUSY}.
REQ-028 The block SHALL contain one sub-module, arb_prio_enc8: a combinational 8-to-3 highest-index priority encoder with a valid output.
REQ-029 Round-robin SHALL be implemented by rotating the masked candidate vector into arb_prio_enc8 and un-rotating the resulting index.
REQ-030 No other sub-modules SHALL be used.

Verification
REQ-031 Reset and idle: rst for 2 cycles, then req=0 -> gnt=0, gnt_valid=0, preempt=0 every cycle.
REQ-032 Fixed priority: rr_en=0, req=8'b0010_0101 -> one cycle later gnt=8'b0010_0000, gnt_id=5; then drop req[5] -> next cycle gnt_id=2, no gap.
REQ-033 Round-robin rotation: rr_en=1, req=8'hFF, each holder drops req for 1 cycle after its grant and then reasserts -> gnt_id sequence 7,6,5,...,0,7.
REQ-034 Timeout: HOLD_MAX=3, req=8'b1000_0001 held constant -> after 3 cycles of holding, preempt=1 and gnt_id moves 7->0, then 0->7 after another 3 cycles.
REQ-035 Lone holder: req=8'b0000_1000 for 40 cycles -> gnt_id=3 throughout and preempt never asserts.
REQ-036 Reset mid-grant: gnt_id=4 active, rst=1 for 1 cycle -> at that edge all outputs are 0; after release, req=8'h11 in round-robin mode -> gnt_id=4 (search starts at 7).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and grant helper for the request arbiter.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        return N_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/arb_prio_enc8.sv
// Combinational 8-to-3 priority encoder: the highest set index wins.
module arb_prio_enc8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    output logic [ID_W-1:0]  idx,
    output logic             valid
);

    // Ascending scan; the last set bit seen is the highest and overrides earlier ones.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec[i]) begin
                idx   = ID_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/request_arbiter.sv
// 8-way arbiter with fixed-priority or round-robin selection and a hold-time limit.
module request_arbiter
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             rr_en,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             preempt
);

    localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);

    state_t           state;
    logic [7:0]       hold_cnt;
    logic [ID_W-1:0]  last_id;

    logic [N_REQ-1:0] holder_mask;
    logic             holder_req;
    logic             others;
    logic             release_c;
    logic             timeout_c;
    logic [N_REQ-1:0] cand;
    logic [2*N_REQ-1:0] cand_dbl;
    logic [N_REQ-1:0] enc_vec;
    logic [ID_W-1:0]  enc_idx;
    logic             enc_valid;
    logic [ID_W-1:0]  win_id;

    assign holder_mask = id_to_onehot(gnt_id);
    assign holder_req  = req[gnt_id];
    assign others      = |(req & ~holder_mask);
    assign release_c   = (state == BUSY) && !holder_req;
    assign timeout_c   = (state == BUSY) && holder_req && (hold_cnt == HOLD_MAX_C) && others;

    // The holder competes only when it is not giving up the resource.
    assign cand = (release_c || timeout_c) ? (req & ~holder_mask) : req;

    // Rotate so that index last_id-1 lands on bit 7; the encoder's highest-wins
    // search then walks downward from there, wrapping through 0 to 7.
    assign cand_dbl = {cand, cand} >> last_id;
    assign enc_vec  = rr_en ? cand_dbl[N_REQ-1:0] : cand;

    arb_prio_enc8 u_enc (
        .vec   (enc_vec),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    assign win_id = rr_en ? (enc_idx + last_id) : enc_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
            hold_cnt  <= '0;
            last_id   <= '0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (enc_valid) begin
                        state     <= BUSY;
                        gnt       <= id_to_onehot(win_id);
                        gnt_id    <= win_id;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        last_id   <= win_id;
                    end
                end
                BUSY: begin
                    if (release_c || timeout_c) begin
                        if (enc_valid) begin
                            gnt      <= id_to_onehot(win_id);
                            gnt_id   <= win_id;
                            hold_cnt <= '0;
                            last_id  <= win_id;
                            preempt  <= timeout_c;
                        end else begin
                            // Only a release can leave nobody to hand over to.
                            state     <= IDLE;
                            gnt       <= '0;
                            gnt_id    <= '0;
                            gnt_valid <= 1'b0;
                            hold_cnt  <= '0;
                        end
                    end else if (others && (hold_cnt != HOLD_MAX_C)) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_request_arbiter.sv
// Directed bench for request_arbiter built with HOLD_MAX=3.
module tb_request_arbiter;

    typedef struct {
        logic       rst;
        logic       rr;
        logic [7:0] req;
        logic       v;
        logic [2:0] id;
        logic       p;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       rr_en;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       preempt;

    int n_checks = 0;
    int n_fail   = 0;
    int step_no  = 0;
    vec_t tbl[$];

    request_arbiter #(.HOLD_MAX(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rr_en     (rr_en),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, step_no, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic rr, input logic [7:0] rq,
                        input logic v, input logic [2:0] id, input logic p);
        logic [7:0] exp_gnt;
        rst   = r;
        rr_en = rr;
        req   = rq;
        @(posedge clk);
        #1;
        step_no++;
        exp_gnt = v ? (8'd1 << id) : 8'd0;
        chk("gnt",       gnt,             exp_gnt);
        chk("gnt_id",    {5'd0, gnt_id},  v ? {5'd0, id} : 8'd0);
        chk("gnt_valid", {7'd0, gnt_valid}, {7'd0, v});
        chk("preempt",   {7'd0, preempt}, {7'd0, p});
    endtask

    function automatic void add(input logic r, input logic rr, input logic [7:0] rq,
                                input logic v, input logic [2:0] id, input logic p);
        vec_t e;
        e.rst = r; e.rr = rr; e.req = rq; e.v = v; e.id = id; e.p = p;
        tbl.push_back(e);
    endfunction

    initial begin
        rst   = 1'b1;
        req   = 8'h00;
        rr_en = 1'b0;

        // reset and idle
        add(1, 0, 8'h00, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0);
        // fixed priority, release without gap, release to idle
        add(0, 0, 8'h25, 1, 5, 0);
        add(0, 0, 8'h05, 1, 2, 0);
        add(0, 0, 8'h04, 1, 2, 0);
        add(0, 0, 8'h00, 0, 0, 0);
        add(0, 0, 8'h01, 1, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0);
        add(0, 0, 8'hFF, 1, 7, 0);
        add(0, 0, 8'h7F, 1, 6, 0);
        add(0, 0, 8'h00, 0, 0, 0);
        // round-robin rotation from a fresh reset
        add(1, 1, 8'h00, 0, 0, 0);
        add(0, 1, 8'hFF, 1, 7, 0);
        add(0, 1, 8'h7F, 1, 6, 0);
        add(0, 1, 8'hBF, 1, 5, 0);
        add(0, 1, 8'hDF, 1, 4, 0);
        add(0, 1, 8'hEF, 1, 3, 0);
        add(0, 1, 8'hF7, 1, 2, 0);
        add(0, 1, 8'hFB, 1, 1, 0);
        add(0, 1, 8'hFD, 1, 0, 0);
        add(0, 1, 8'hFE, 1, 7, 0);
        add(0, 1, 8'h00, 0, 0, 0);
        // mode change leaves the active grant alone; next decision uses new mode
        add(0, 1, 8'h11, 1, 4, 0);
        add(0, 0, 8'h10, 1, 4, 0);
        add(0, 0, 8'h00, 0, 0, 0);
        add(0, 1, 8'h21, 1, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0);
        // timeout ping-pong, then release coinciding with timeout
        add(0, 0, 8'h81, 1, 7, 0);
        add(0, 0, 8'h81, 1, 7, 0);
        add(0, 0, 8'h81, 1, 7, 0);
        add(0, 0, 8'h81, 1, 7, 0);
        add(0, 0, 8'h81, 1, 0, 1);
        add(0, 0, 8'h81, 1, 0, 0);
        add(0, 0, 8'h81, 1, 0, 0);
        add(0, 0, 8'h81, 1, 0, 0);
        add(0, 0, 8'h81, 1, 7, 1);
        add(0, 0, 8'h81, 1, 7, 0);
        add(0, 0, 8'h81, 1, 7, 0);
        add(0, 0, 8'h81, 1, 7, 0);
        add(0, 0, 8'h01, 1, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0);
        // reset mid-grant, then round-robin search restarts at 7
        add(0, 0, 8'h10, 1, 4, 0);
        add(1, 0, 8'h10, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0);
        add(0, 1, 8'h11, 1, 4, 0);
        add(0, 1, 8'h00, 0, 0, 0);

        foreach (tbl[i])
            step(tbl[i].rst, tbl[i].rr, tbl[i].req, tbl[i].v, tbl[i].id, tbl[i].p);

        // lone holder never times out
        for (int k = 0; k < 40; k++)
            step(0, 0, 8'h08, 1, 3, 0);

        // counter saturates; pending requests vanish exactly at the limit
        for (int k = 0; k < 3; k++)
            step(0, 0, 8'h0C, 1, 3, 0);
        step(0, 0, 8'h08, 1, 3, 0);
        step(0, 0, 8'h08, 1, 3, 0);
        // a competitor reappearing with the counter still saturated preempts at once
        step(0, 0, 8'h0C, 1, 2, 1);
        step(0, 0, 8'h00, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
